// File: rtl/debounced_updown_counter.sv
// Debounced pushbutton up/down counter.
// Raw button and direction switch are synchronised, the button is debounced
// by a four-state FSM, and each accepted press moves the count by one step,
// either wrapping modulo MAX_VALUE+1 or clamping at 0 / MAX_VALUE.
module debounced_updown_counter #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_VALUE       = 2**WIDTH-1,
    parameter bit          SATURATE        = 1'b0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             pushButton,
    input  logic             slideSwitch,
    input  logic             clear,
    output logic [WIDTH-1:0] LEDS,
    output logic             stepPulse,
    output logic             limitPulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } dbState_t;

    logic [1:0]       btnSync_q;
    logic [1:0]       dirSync_q;
    logic             btnS;
    logic             dirS;

    dbState_t         state_q;
    logic [CntW-1:0]  dbCnt_q;
    logic             stepReq_q;

    logic [WIDTH-1:0] count_q, count_d;
    logic             stepPulse_q, stepPulse_d;
    logic             limitPulse_q, limitPulse_d;

    assign btnS = btnSync_q[1];
    assign dirS = dirSync_q[1];

    // Two-flop synchronisers bring the raw button and switch into the clk domain.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            btnSync_q <= 2'b00;
            dirSync_q <= 2'b00;
        end else begin
            btnSync_q <= {btnSync_q[0], pushButton};
            dirSync_q <= {dirSync_q[0], slideSwitch};
        end
    end

    // Debounce FSM: a new level must persist before it is accepted; only a rising acceptance requests a step.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= STABLE_LOW;
            dbCnt_q   <= '0;
            stepReq_q <= 1'b0;
        end else begin
            stepReq_q <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    dbCnt_q <= '0;
                    if (btnS) begin
                        state_q <= CHECK_HIGH;
                    end
                end
                CHECK_HIGH: begin
                    if (!btnS) begin
                        state_q <= STABLE_LOW;
                        dbCnt_q <= '0;
                    end else if (dbCnt_q == CntLast) begin
                        state_q   <= STABLE_HIGH;
                        dbCnt_q   <= '0;
                        stepReq_q <= 1'b1;
                    end else begin
                        dbCnt_q <= dbCnt_q + CntW'(1);
                    end
                end
                STABLE_HIGH: begin
                    dbCnt_q <= '0;
                    if (!btnS) begin
                        state_q <= CHECK_LOW;
                    end
                end
                CHECK_LOW: begin
                    if (btnS) begin
                        state_q <= STABLE_HIGH;
                        dbCnt_q <= '0;
                    end else if (dbCnt_q == CntLast) begin
                        state_q <= STABLE_LOW;
                        dbCnt_q <= '0;
                    end else begin
                        dbCnt_q <= dbCnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    dbCnt_q <= '0;
                end
            endcase
        end
    end

    // Next count and strobes: clear wins over a pending step; bounds are compared explicitly.
    always_comb begin
        count_d      = count_q;
        stepPulse_d  = 1'b0;
        limitPulse_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (stepReq_q) begin
            stepPulse_d = 1'b1;
            if (dirS) begin
                if (count_q >= MaxVal) begin
                    limitPulse_d = 1'b1;
                    count_d      = SATURATE ? MaxVal : '0;
                end else begin
                    count_d = count_q + OneVal;
                end
            end else begin
                if (count_q == '0) begin
                    limitPulse_d = 1'b1;
                    count_d      = SATURATE ? '0 : MaxVal;
                end else begin
                    count_d = count_q - OneVal;
                end
            end
        end
    end

    // Count and strobe registers feeding the LED bank and downstream logic.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q      <= '0;
            stepPulse_q  <= 1'b0;
            limitPulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            stepPulse_q  <= stepPulse_d;
            limitPulse_q <= limitPulse_d;
        end
    end

    assign LEDS       = count_q;
    assign stepPulse  = stepPulse_q;
    assign limitPulse = limitPulse_q;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: a wrapping and a saturating instance
// share the same stimulus and are checked against hand-computed vectors.
module tb_debounced_updown_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetN;
    logic         pushButton;
    logic         slideSwitch;
    logic         clear;
    logic [W-1:0] ledsW, ledsS;
    logic         stepW, stepS, limW, limS;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    int stepCntW = 0, stepCntS = 0, limCntW = 0, limCntS = 0;
    int stepCycW = 0, stepCycS = 0;
    int stepLedsW = 0, stepLedsS = 0;
    int stepLimW = 0, stepLimS = 0;

    typedef struct {
        logic dir;
        logic clr;
        int   expW;
        int   limWe;
        int   expS;
        int   limSe;
    } vec_t;

    vec_t vecs[15];

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(4), .MAX_VALUE(9), .SATURATE(1'b0)
    ) dutWrap (
        .clk(clk), .resetN(resetN), .pushButton(pushButton),
        .slideSwitch(slideSwitch), .clear(clear),
        .LEDS(ledsW), .stepPulse(stepW), .limitPulse(limW)
    );

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(4), .MAX_VALUE(9), .SATURATE(1'b1)
    ) dutSat (
        .clk(clk), .resetN(resetN), .pushButton(pushButton),
        .slideSwitch(slideSwitch), .clear(clear),
        .LEDS(ledsS), .stepPulse(stepS), .limitPulse(limS)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in cycles.
    always @(posedge clk) cycleNo++;

    // Record every strobe seen on the falling edge, with the count at that moment.
    always @(negedge clk) begin
        if (stepW) begin
            stepCntW++;
            stepCycW  = cycleNo;
            stepLedsW = int'(ledsW);
            stepLimW  = int'(limW);
        end
        if (stepS) begin
            stepCntS++;
            stepCycS  = cycleNo;
            stepLedsS = int'(ledsS);
            stepLimS  = int'(limS);
        end
        if (limW) limCntW++;
        if (limS) limCntS++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One clean press: set direction, hold the button, release it, and let it settle.
    task automatic applyStimulus(input logic dir, input int hold, input int rel, output int pressCyc);
        slideSwitch = dir;
        waitCycles(3);
        pressCyc   = cycleNo;
        pushButton = 1'b1;
        waitCycles(hold);
        pushButton = 1'b0;
        waitCycles(rel);
    endtask

    task automatic doPress(input string name, input logic dir,
                           input int expW, input int limWe, input int expS, input int limSe);
        int sw0 = stepCntW;
        int ss0 = stepCntS;
        int lw0 = limCntW;
        int ls0 = limCntS;
        int pc;
        applyStimulus(dir, 10, 10, pc);
        checkOutput({name, " stepsW"}, stepCntW - sw0, 1);
        checkOutput({name, " stepsS"}, stepCntS - ss0, 1);
        checkOutput({name, " latencyW"}, stepCycW - pc, 8);
        checkOutput({name, " latencyS"}, stepCycS - pc, 8);
        checkOutput({name, " ledsW@step"}, stepLedsW, expW);
        checkOutput({name, " limW@step"}, stepLimW, limWe);
        checkOutput({name, " ledsS@step"}, stepLedsS, expS);
        checkOutput({name, " limS@step"}, stepLimS, limSe);
        checkOutput({name, " limitsW"}, limCntW - lw0, limWe);
        checkOutput({name, " limitsS"}, limCntS - ls0, limSe);
        checkOutput({name, " ledsW"}, int'(ledsW), expW);
        checkOutput({name, " ledsS"}, int'(ledsS), expS);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        waitCycles(1);
    endtask

    initial begin
        int pc, rc, sw0, ss0, lw0, ls0;

        vecs[0]  = '{1'b1, 1'b0, 1, 0, 1, 0};
        vecs[1]  = '{1'b1, 1'b0, 2, 0, 2, 0};
        vecs[2]  = '{1'b1, 1'b0, 3, 0, 3, 0};
        vecs[3]  = '{1'b1, 1'b0, 4, 0, 4, 0};
        vecs[4]  = '{1'b1, 1'b0, 5, 0, 5, 0};
        vecs[5]  = '{1'b1, 1'b0, 6, 0, 6, 0};
        vecs[6]  = '{1'b1, 1'b0, 7, 0, 7, 0};
        vecs[7]  = '{1'b1, 1'b0, 8, 0, 8, 0};
        vecs[8]  = '{1'b1, 1'b0, 9, 0, 9, 0};
        vecs[9]  = '{1'b1, 1'b0, 0, 1, 9, 1};
        vecs[10] = '{1'b0, 1'b0, 9, 1, 8, 0};
        vecs[11] = '{1'b0, 1'b1, 9, 1, 0, 1};
        vecs[12] = '{1'b1, 1'b0, 0, 1, 1, 0};
        vecs[13] = '{1'b0, 1'b0, 9, 1, 0, 0};
        vecs[14] = '{1'b0, 1'b0, 8, 0, 0, 1};

        resetN      = 1'b0;
        pushButton  = 1'b0;
        slideSwitch = 1'b1;
        clear       = 1'b0;
        waitCycles(3);
        checkOutput("reset ledsW", int'(ledsW), 0);
        checkOutput("reset ledsS", int'(ledsS), 0);
        checkOutput("reset stepW", int'(stepW), 0);
        checkOutput("reset limW", int'(limW), 0);
        resetN = 1'b1;
        waitCycles(3);

        $display("[TB] table-driven presses");
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].clr) begin
                pulseClear();
                checkOutput($sformatf("vec%0d clrW", i), int'(ledsW), 0);
                checkOutput($sformatf("vec%0d clrS", i), int'(ledsS), 0);
            end
            doPress($sformatf("vec%0d", i), vecs[i].dir,
                    vecs[i].expW, vecs[i].limWe, vecs[i].expS, vecs[i].limSe);
        end

        $display("[TB] clear colliding with a step");
        pulseClear();
        for (int i = 1; i <= 5; i++) doPress($sformatf("pre5_%0d", i), 1'b1, i, 0, i, 0);
        sw0 = stepCntW; ss0 = stepCntS; lw0 = limCntW; ls0 = limCntS;
        slideSwitch = 1'b1;
        waitCycles(3);
        pushButton = 1'b1;
        waitCycles(7);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        waitCycles(2);
        pushButton = 1'b0;
        waitCycles(10);
        checkOutput("clr steps W", stepCntW - sw0, 0);
        checkOutput("clr steps S", stepCntS - ss0, 0);
        checkOutput("clr limits W", limCntW - lw0, 0);
        checkOutput("clr limits S", limCntS - ls0, 0);
        checkOutput("clr ledsW", int'(ledsW), 0);
        checkOutput("clr ledsS", int'(ledsS), 0);
        doPress("after clr", 1'b1, 1, 0, 1, 0);

        $display("[TB] bouncing button and short pulse");
        sw0 = stepCntW; ss0 = stepCntS;
        pushButton = 1'b1;
        waitCycles(2);
        pushButton = 1'b0;
        waitCycles(1);
        rc = cycleNo;
        pushButton = 1'b1;
        waitCycles(22);
        pushButton = 1'b0;
        waitCycles(10);
        checkOutput("bounce stepsW", stepCntW - sw0, 1);
        checkOutput("bounce stepsS", stepCntS - ss0, 1);
        checkOutput("bounce latency", stepCycW - rc, 8);
        checkOutput("bounce ledsW", int'(ledsW), 2);
        checkOutput("bounce ledsS", int'(ledsS), 2);
        sw0 = stepCntW;
        pushButton = 1'b1;
        waitCycles(3);
        pushButton = 1'b0;
        waitCycles(10);
        checkOutput("glitch steps", stepCntW - sw0, 0);
        checkOutput("glitch ledsW", int'(ledsW), 2);

        $display("[TB] reset during debounce");
        for (int i = 3; i <= 7; i++) doPress($sformatf("pre7_%0d", i), 1'b1, i, 0, i, 0);
        sw0 = stepCntW; ss0 = stepCntS; lw0 = limCntW;
        slideSwitch = 1'b1;
        waitCycles(3);
        pushButton = 1'b1;
        waitCycles(4);
        resetN = 1'b0;
        #1;
        checkOutput("async rst ledsW", int'(ledsW), 0);
        checkOutput("async rst ledsS", int'(ledsS), 0);
        checkOutput("async rst stepW", int'(stepW), 0);
        waitCycles(2);
        resetN = 1'b1;
        rc = cycleNo;
        waitCycles(10);
        slideSwitch = 1'b0;
        waitCycles(10);
        pushButton = 1'b0;
        waitCycles(10);
        checkOutput("rst stepsW", stepCntW - sw0, 1);
        checkOutput("rst stepsS", stepCntS - ss0, 1);
        checkOutput("rst latency", stepCycW - rc, 8);
        checkOutput("rst limits", limCntW - lw0, 0);
        checkOutput("rst ledsW", int'(ledsW), 1);
        checkOutput("rst ledsS", int'(ledsS), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
